// File: rtl/oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter
//
// Owns the single memory port shared by the CPU, the PPU fetcher and the OAM
// DMA engine. A granted CPU write to FF46 launches a DMA_LEN-byte copy from
// {src,8'h00} into FE00.. . Port ownership is decided every cycle by fixed
// priority: DMA read/write slot, then PPU fetch, then CPU. Accesses that the
// bus lockouts forbid complete immediately without touching the port
// (reads return FF, writes are dropped).
//
// Optional feature macro: PPU_MODE_LOCK_EN
//   defined   : CPU access to VRAM (8000-9FFF) is locked out in DRAW mode and
//               CPU access to OAM (FE00-FE9F) in SCAN/DRAW mode.
//   undefined : ppu_mode is ignored; only the DMA lockout applies.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   cpu_addr/rd/wr/wdata   CPU request (rd+wr together is a write)
//   cpu_rdata              CPU read data, valid the cycle after the grant
//   cpu_wait               CPU request present but not granted this cycle
//   ppu_mode               PPU mode (0 HBLANK, 1 VBLANK, 2 SCAN, 3 DRAW)
//   ppu_rd/ppu_addr        PPU fetch request
//   ppu_gnt                PPU fetch accepted this cycle (combinational)
//   ppu_rdata              PPU read data, valid the cycle after ppu_gnt
//   mem_addr/rd/wr/wdata   shared port request; mem_rdata valid next cycle
//   mem_rdata              shared port read data
//   dma_active             DMA in progress, start delay included
// -----------------------------------------------------------------------------
module oam_dma_arbiter #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int START_DELAY     = 4,
   parameter int DMA_LEN         = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_wait,
   input  logic [1:0]  ppu_mode,
   input  logic        ppu_rd,
   input  logic [15:0] ppu_addr,
   output logic        ppu_gnt,
   output logic [7:0]  ppu_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active
);

   localparam int PW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
   localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
   localparam logic [PW-1:0] PH_WRITE = PW'(1);
   localparam logic [7:0]    IDX_LAST = 8'(DMA_LEN - 1);
   // DELAY lasts START_DELAY-1 cycles so the byte-0 read lands exactly
   // START_DELAY clocks after the cycle in which FF46 was written.
   localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [7:0]    src_reg, src_next;
   logic [7:0]    idx_reg, idx_next;
   logic [PW-1:0] phase_reg, phase_next;
   logic [DW-1:0] dcnt_reg, dcnt_next;

   logic cpu_req, cpu_blocked, cpu_use, mode_block;
   logic ppu_blocked, ppu_use;
   logic dma_slot, dma_start;
   logic [7:0] src_mapped;

   assign dma_active = (state_reg != ST_IDLE);
   assign dma_slot   = (state_reg == ST_XFER) &&
                       ((phase_reg == '0) || (phase_reg == PH_WRITE));

`ifdef PPU_MODE_LOCK_EN
   assign mode_block = ((ppu_mode == 2'd3) &&
                        (cpu_addr >= 16'h8000) && (cpu_addr <= 16'h9FFF)) ||
                       (ppu_mode[1] &&
                        (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F));
`else
   logic unused_mode;
   assign unused_mode = ^ppu_mode;
   assign mode_block  = 1'b0;
`endif

   // Locked-out requests never need the port, so they are resolved before
   // arbitration and never wait.
   assign cpu_req     = cpu_rd | cpu_wr;
   assign cpu_blocked = cpu_req &&
                        ((dma_active && (cpu_addr < 16'hFF00)) || mode_block);
   assign ppu_blocked = ppu_rd && dma_active &&
                        (ppu_addr >= 16'hFE00) && (ppu_addr <= 16'hFE9F);

   assign ppu_use  = ppu_rd && !ppu_blocked && !dma_slot;
   assign cpu_use  = cpu_req && !cpu_blocked && !dma_slot && !ppu_use;
   assign cpu_wait = cpu_req && !cpu_blocked && !cpu_use;
   assign ppu_gnt  = ppu_blocked || ppu_use;

   assign dma_start  = cpu_use && cpu_wr && (cpu_addr == 16'hFF46);
   // Sources at E0xx and above would read echo/OAM/IO space; fold them down.
   assign src_mapped = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;

   // Shared port mux
   always_comb begin
      mem_addr  = 16'h0000;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wdata = 8'h00;
      if (dma_slot) begin
         if (phase_reg == '0) begin
            mem_rd   = 1'b1;
            mem_addr = {src_reg, 8'h00} + {8'h00, idx_reg};
         end else begin
            // Data read in phase 0 is presented by memory this cycle.
            mem_wr    = 1'b1;
            mem_addr  = 16'hFE00 + {8'h00, idx_reg};
            mem_wdata = mem_rdata;
         end
      end else if (ppu_use) begin
         mem_rd   = 1'b1;
         mem_addr = ppu_addr;
      end else if (cpu_use) begin
         mem_addr  = cpu_addr;
         mem_wr    = cpu_wr;
         mem_rd    = ~cpu_wr;
         mem_wdata = cpu_wdata;
      end
   end

   // DMA sequencer, next state
   always_comb begin
      state_next = state_reg;
      src_next   = src_reg;
      idx_next   = idx_reg;
      phase_next = phase_reg;
      dcnt_next  = dcnt_reg;
      case (state_reg)
         ST_DELAY: begin
            if (dcnt_reg == DLY_LAST) begin
               state_next = ST_XFER;
               idx_next   = 8'h00;
               phase_next = '0;
            end else begin
               dcnt_next = dcnt_reg + 1'b1;
            end
         end
         ST_XFER: begin
            if ((phase_reg == PH_WRITE) && (idx_reg == IDX_LAST)) begin
               state_next = ST_IDLE;
               idx_next   = 8'h00;
               phase_next = '0;
            end else if (phase_reg == PH_LAST) begin
               phase_next = '0;
               idx_next   = idx_reg + 8'h01;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         default: ;
      endcase
      // A granted FF46 write (re)starts from any state.
      if (dma_start) begin
         state_next = ST_DELAY;
         src_next   = src_mapped;
         idx_next   = 8'h00;
         phase_next = '0;
         dcnt_next  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         src_reg   <= 8'h00;
         idx_reg   <= 8'h00;
         phase_reg <= '0;
         dcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         src_reg   <= src_next;
         idx_reg   <= idx_next;
         phase_reg <= phase_next;
         dcnt_reg  <= dcnt_next;
      end
   end

   // Read-return paths: channel 0 = CPU, channel 1 = PPU. A served read passes
   // mem_rdata straight through in the following cycle; a locked-out read
   // returns FF. The last value is held otherwise.
   logic [1:0]      ret_served, ret_blocked;
   logic [1:0][7:0] ret_data;

   assign ret_served  = {ppu_use, cpu_use && !cpu_wr};
   assign ret_blocked = {ppu_blocked, cpu_blocked && !cpu_wr};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ret
         logic       pend_reg;
         logic [7:0] hold_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pend_reg <= 1'b0;
               hold_reg <= 8'hFF;
            end else begin
               pend_reg <= ret_served[gi];
               if (ret_blocked[gi]) begin
                  hold_reg <= 8'hFF;
               end else if (pend_reg) begin
                  hold_reg <= mem_rdata;
               end
            end
         end
         assign ret_data[gi] = pend_reg ? mem_rdata : hold_reg;
      end
   endgenerate

   assign cpu_rdata = ret_data[0];
   assign ppu_rdata = ret_data[1];

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_arbiter
//
// Drives oam_dma_arbiter against a byte-array memory model and checks port
// grants, lockouts and DMA copies against expectations computed from the
// arbiter's rules (slot timing from clock offsets, data from memory snapshots).
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, registered read data on the next falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oam_dma_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic        cpu_rd, cpu_wr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        cpu_wait;
   logic [1:0]  ppu_mode;
   logic        ppu_rd;
   logic [15:0] ppu_addr;
   logic        ppu_gnt;
   logic [7:0]  ppu_rdata;
   logic [15:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        dma_active;

`ifdef PPU_MODE_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   always #5 clk = ~clk;

   oam_dma_arbiter #(.CYCLES_PER_BYTE(4), .START_DELAY(4), .DMA_LEN(160)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
      .ppu_mode(ppu_mode), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
      .ppu_gnt(ppu_gnt), .ppu_rdata(ppu_rdata),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dma_active(dma_active)
   );

   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic drive_idle();
      cpu_rd = 0; cpu_wr = 0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      ppu_rd = 0; ppu_addr = 16'h0000;
   endtask

   // One-cycle FF46 write; returns the clock index of the write cycle and
   // leaves the bench in the low phase of the following cycle.
   task automatic start_dma(input logic [7:0] w, output int s);
      @(negedge clk);
      cpu_wr = 1; cpu_addr = 16'hFF46; cpu_wdata = w;
      #1; s = cyc;
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_reset();
      rst = 0; ppu_mode = 2'd0; drive_idle();
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({cpu_rdata, ppu_rdata} !== 16'hFFFF) begin
         n_fail++; $display("FAIL reset_rdata: got %h/%h want FF/FF", cpu_rdata, ppu_rdata);
      end
      n_tests++;
      if ({dma_active, mem_rd, mem_wr, cpu_wait, ppu_gnt} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000",
                            {dma_active, mem_rd, mem_wr, cpu_wait, ppu_gnt});
      end
      n_tests++;
      if ({mem_addr, mem_wdata} !== 24'h0) begin
         n_fail++; $display("FAIL reset_bus: got %h/%h want 0000/00", mem_addr, mem_wdata);
      end
      @(negedge clk); rst = 1;
      @(negedge clk);
      $display("[TB] reset checked");
   endtask

   task automatic test_cpu_access();
      logic [15:0] a;
      logic [7:0]  d, exp;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         a = 16'($urandom_range(0, 16'hFEFF));
         cpu_rd = 1; cpu_addr = a;
         #1;
         exp = mem[a];
         n_tests++;
         if (!(mem_rd === 1'b1 && mem_wr === 1'b0 && mem_addr === a && cpu_wait === 1'b0)) begin
            n_fail++; $display("FAIL cpu_rd_port: rd=%b wr=%b addr=%h wait=%b want 1/0/%h/0",
                               mem_rd, mem_wr, mem_addr, cpu_wait, a);
         end
         @(negedge clk);
         n_tests++;
         if (cpu_rdata !== exp) begin
            n_fail++; $display("FAIL cpu_rdata: addr %h got %h want %h", a, cpu_rdata, exp);
         end
         drive_idle();
         $display("[TB] cpu read %h -> %h", a, exp);
      end
      // rd and wr together behave as a write
      @(negedge clk);
      a = 16'hC000 + 16'($urandom_range(0, 16'h1FFF)); d = 8'($urandom);
      cpu_rd = 1; cpu_wr = 1; cpu_addr = a; cpu_wdata = d;
      #1;
      n_tests++;
      if (!(mem_wr === 1'b1 && mem_rd === 1'b0 && mem_addr === a && mem_wdata === d)) begin
         n_fail++; $display("FAIL cpu_rdwr: wr=%b rd=%b addr=%h data=%h want 1/0/%h/%h",
                            mem_wr, mem_rd, mem_addr, mem_wdata, a, d);
      end
      @(negedge clk); drive_idle();
      $display("[TB] cpu rd+wr %h <- %h", a, d);
   endtask

   task automatic test_priority();
      logic [15:0] pa;
      logic [7:0]  exp;
      @(negedge clk);
      pa = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
      ppu_rd = 1; ppu_addr = pa; cpu_rd = 1; cpu_addr = 16'hC010;
      #1;
      exp = mem[pa];
      n_tests++;
      if (!(ppu_gnt === 1'b1 && cpu_wait === 1'b1 && mem_rd === 1'b1 && mem_addr === pa)) begin
         n_fail++; $display("FAIL ppu_over_cpu: gnt=%b wait=%b rd=%b addr=%h want 1/1/1/%h",
                            ppu_gnt, cpu_wait, mem_rd, mem_addr, pa);
      end
      @(negedge clk);
      n_tests++;
      if (ppu_rdata !== exp) begin
         n_fail++; $display("FAIL ppu_rdata: got %h want %h", ppu_rdata, exp);
      end
      drive_idle();
      $display("[TB] ppu %h beats cpu", pa);
   endtask

   task automatic test_dma_full(input logic [7:0] w);
      logic [7:0] eff;
      logic [7:0] exp [160];
      int s, off, nw, first_rd_off, drop_off;
      logic [15:0] first_rd_addr;
      eff = (w >= 8'hE0) ? w - 8'h20 : w;
      for (int i = 0; i < 160; i++) exp[i] = mem[{eff, 8'h00} + 16'(i)];
      nw = 0; first_rd_off = -1; drop_off = -1; first_rd_addr = 16'h0;
      start_dma(w, s);
      for (int k = 0; k < 700; k++) begin
         #1;
         off = cyc - s;
         if (off == 1) begin
            n_tests++;
            if (dma_active !== 1'b1) begin
               n_fail++; $display("FAIL dma_active_rise: got %b want 1", dma_active);
            end
         end
         if (mem_rd && first_rd_off < 0) begin
            first_rd_off = off; first_rd_addr = mem_addr;
         end
         if (mem_wr && mem_addr[15:8] == 8'hFE) begin
            n_tests++;
            if (nw >= 160 || mem_addr !== 16'hFE00 + 16'(nw) || mem_wdata !== exp[nw] ||
                off != 5 + 4 * nw) begin
               n_fail++; $display("FAIL dma_write %0d: addr=%h data=%h off=%0d want %h/%h/%0d",
                                  nw, mem_addr, mem_wdata, off, 16'hFE00 + 16'(nw),
                                  exp[nw % 160], 5 + 4 * nw);
            end
            nw++;
         end
         if (!dma_active) begin
            drop_off = off; break;
         end
         @(negedge clk);
      end
      n_tests++;
      if (first_rd_off != 4 || first_rd_addr !== {eff, 8'h00}) begin
         n_fail++; $display("FAIL dma_first_read: off=%0d addr=%h want 4/%h",
                            first_rd_off, first_rd_addr, {eff, 8'h00});
      end
      n_tests++;
      if (nw != 160) begin
         n_fail++; $display("FAIL dma_count: got %0d writes want 160", nw);
      end
      n_tests++;
      if (drop_off != 642) begin
         n_fail++; $display("FAIL dma_drop: dma_active fell at offset %0d want 642", drop_off);
      end
      for (int i = 0; i < 160; i++) begin
         if (mem[16'hFE00 + 16'(i)] !== exp[i]) begin
            n_tests++; n_fail++;
            $display("FAIL oam_content %0d: got %h want %h", i, mem[16'hFE00 + 16'(i)], exp[i]);
            break;
         end
      end
      $display("[TB] dma ff46=%h src=%h00 writes=%0d drop@%0d", w, eff, nw, drop_off);
   endtask

   task automatic test_dma_blocking();
      int s, off, cc, pc, ph, bi;
      bit slot, ppu_real, cpu_real, exp_rd, exp_wr, exp_wait, exp_gnt;
      bit cpu_chk, ppu_chk;
      logic [7:0]  cpu_exp, ppu_exp;
      logic [15:0] exp_addr;
      cpu_chk = 0; ppu_chk = 0; cpu_exp = 8'h00; ppu_exp = 8'h00;
      start_dma(8'hC4, s);
      for (int k = 0; k < 67; k++) begin
         n_tests++;
         if ((cpu_chk && cpu_rdata !== cpu_exp) || (ppu_chk && ppu_rdata !== ppu_exp)) begin
            n_fail++; $display("FAIL blk_rdata: cpu %h/%h ppu %h/%h (got/want)",
                               cpu_rdata, cpu_exp, ppu_rdata, ppu_exp);
         end
         off = cyc - s;
         slot = (off >= 4) && (((off - 4) % 4) < 2);
         ph = (off - 4) % 4; bi = (off - 4) / 4;
         drive_idle();
         cc = $urandom_range(0, 3); pc = $urandom_range(0, 2);
         case (cc)
            1: begin cpu_rd = 1; cpu_addr = 16'($urandom_range(0, 16'hFEFF)); end
            2: begin cpu_rd = 1; cpu_addr = 16'hFF80 + 16'($urandom_range(0, 126)); end
            3: begin cpu_wr = 1; cpu_addr = 16'($urandom_range(0, 16'hFEFF));
                     cpu_wdata = 8'($urandom); end
            default: ;
         endcase
         if (pc == 1) begin ppu_rd = 1; ppu_addr = 16'hFE00 + 16'($urandom_range(0, 159)); end
         if (pc == 2) begin ppu_rd = 1; ppu_addr = 16'h8000 + 16'($urandom_range(0, 16'h1FFF)); end
         #1;
         ppu_real = (pc == 2) && !slot;
         exp_gnt  = (pc == 1) || ppu_real;
         cpu_real = (cc == 2) && !slot && !ppu_real;
         exp_wait = (cc == 2) && !cpu_real;
         exp_rd = 0; exp_wr = 0; exp_addr = 16'h0;
         if (slot && ph == 0) begin exp_rd = 1; exp_addr = 16'hC400 + 16'(bi); end
         else if (slot)       begin exp_wr = 1; exp_addr = 16'hFE00 + 16'(bi); end
         else if (ppu_real)   begin exp_rd = 1; exp_addr = ppu_addr; end
         else if (cpu_real)   begin exp_rd = 1; exp_addr = cpu_addr; end
         n_tests++;
         if (cpu_wait !== exp_wait || ppu_gnt !== exp_gnt || mem_rd !== exp_rd ||
             mem_wr !== exp_wr || ((exp_rd || exp_wr) && mem_addr !== exp_addr)) begin
            n_fail++;
            $display("FAIL blk_cycle off=%0d cc=%0d pc=%0d: wait=%b gnt=%b rd=%b wr=%b addr=%h want %b/%b/%b/%b/%h",
                     off, cc, pc, cpu_wait, ppu_gnt, mem_rd, mem_wr, mem_addr,
                     exp_wait, exp_gnt, exp_rd, exp_wr, exp_addr);
         end
         cpu_chk = (cc == 1) || cpu_real;
         cpu_exp = (cc == 1) ? 8'hFF : mem[cpu_addr];
         ppu_chk = (pc == 1) || ppu_real;
         ppu_exp = (pc == 1) ? 8'hFF : mem[ppu_addr];
         $display("[TB] blk off=%0d cpu=%0d ppu=%0d wait=%b gnt=%b", off, cc, pc, cpu_wait, ppu_gnt);
         @(negedge clk);
      end
      drive_idle();
      for (int k = 0; k < 800 && dma_active; k++) @(negedge clk);
      n_tests++;
      if (dma_active !== 1'b0) begin
         n_fail++; $display("FAIL blk_finish: dma_active=%b want 0", dma_active);
      end
   endtask

   task automatic test_restart();
      logic [7:0] expd [160];
      int s, g, nw, waits, off, rd_off, wr_off;
      bit found, first_wait, dma_won;
      logic [15:0] rd_addr, wr_addr;
      logic [7:0]  wr_data;
      for (int i = 0; i < 160; i++) expd[i] = mem[16'hD000 + 16'(i)];
      nw = 0; found = 0; g = -1; waits = 0; rd_off = -1; wr_off = -1;
      rd_addr = 0; wr_addr = 0; wr_data = 0;
      start_dma(8'hC0, s);
      for (int k = 0; k < 800; k++) begin
         #1;
         if (mem_wr && mem_addr[15:8] == 8'hFE) nw++;
         if (nw >= 50 && mem_rd && mem_addr[15:8] == 8'hC0) begin found = 1; break; end
         @(negedge clk);
      end
      // FF46 write arrives in the same cycle as a DMA read slot
      cpu_wr = 1; cpu_addr = 16'hFF46; cpu_wdata = 8'hD0;
      #1;
      first_wait = cpu_wait;
      dma_won = mem_rd && (mem_addr[15:8] == 8'hC0);
      n_tests++;
      if (!(found && first_wait === 1'b1 && dma_won)) begin
         n_fail++; $display("FAIL restart_collide: found=%b wait=%b dma_rd=%b want 1/1/1",
                            found, first_wait, dma_won);
      end
      waits = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (!cpu_wait) begin g = cyc; break; end
         waits++;
      end
      n_tests++;
      if (g < 0 || waits != 2) begin
         n_fail++; $display("FAIL restart_wait: waited %0d cycles granted=%0d want 2/1", waits, g >= 0);
      end
      @(negedge clk); drive_idle();
      for (int k = 0; k < 700; k++) begin
         #1;
         off = cyc - g;
         if (mem_rd && rd_off < 0) begin rd_off = off; rd_addr = mem_addr; end
         if (mem_wr && wr_off < 0) begin wr_off = off; wr_addr = mem_addr; wr_data = mem_wdata; end
         if (!dma_active) break;
         @(negedge clk);
      end
      n_tests++;
      if (rd_off != 4 || rd_addr !== 16'hD000) begin
         n_fail++; $display("FAIL restart_read: off=%0d addr=%h want 4/D000", rd_off, rd_addr);
      end
      n_tests++;
      if (wr_off != 5 || wr_addr !== 16'hFE00 || wr_data !== expd[0]) begin
         n_fail++; $display("FAIL restart_write: off=%0d addr=%h data=%h want 5/FE00/%h",
                            wr_off, wr_addr, wr_data, expd[0]);
      end
      n_tests++;
      if (dma_active !== 1'b0 || mem[16'hFE9F] !== expd[159] || mem[16'hFE31] !== expd[49]) begin
         n_fail++; $display("FAIL restart_content: active=%b FE31=%h FE9F=%h want 0/%h/%h",
                            dma_active, mem[16'hFE31], mem[16'hFE9F], expd[49], expd[159]);
      end
      $display("[TB] restart C0->D0 after %0d bytes, waits=%0d", nw, waits);
   endtask

   task automatic test_reset_abort();
      int s, stray;
      stray = 0;
      start_dma(8'hC3, s);
      repeat (30) @(negedge clk);
      rst = 0;
      #1;
      n_tests++;
      if ({dma_active, mem_rd, mem_wr} !== 3'b000) begin
         n_fail++; $display("FAIL abort_now: active/rd/wr=%b want 000", {dma_active, mem_rd, mem_wr});
      end
      @(negedge clk); rst = 1;
      for (int k = 0; k < 60; k++) begin
         #1; if (mem_wr || dma_active) stray++;
         @(negedge clk);
      end
      n_tests++;
      if (stray != 0) begin
         n_fail++; $display("FAIL abort_after: %0d active/write cycles want 0", stray);
      end
      $display("[TB] reset mid-transfer, stray=%0d", stray);
   endtask

   task automatic test_mode_lock();
      logic [7:0] exp;
      // VRAM write in DRAW
      @(negedge clk); ppu_mode = 2'd3;
      cpu_wr = 1; cpu_addr = 16'h9000; cpu_wdata = 8'h5A;
      #1;
      n_tests++;
      if (mem_wr !== !LOCK || cpu_wait !== 1'b0) begin
         n_fail++; $display("FAIL lock_vram_draw: wr=%b wait=%b want %b/0", mem_wr, cpu_wait, !LOCK);
      end
      // VRAM write in HBLANK
      @(negedge clk); ppu_mode = 2'd0;
      #1;
      n_tests++;
      if (mem_wr !== 1'b1 || mem_addr !== 16'h9000) begin
         n_fail++; $display("FAIL lock_vram_hblank: wr=%b addr=%h want 1/9000", mem_wr, mem_addr);
      end
      // OAM write in SCAN
      @(negedge clk); ppu_mode = 2'd2; cpu_addr = 16'hFE20;
      #1;
      n_tests++;
      if (mem_wr !== !LOCK) begin
         n_fail++; $display("FAIL lock_oam_scan: wr=%b want %b", mem_wr, !LOCK);
      end
      // VRAM read in DRAW
      @(negedge clk); ppu_mode = 2'd3; cpu_wr = 0; cpu_rd = 1; cpu_addr = 16'h8800;
      #1;
      exp = LOCK ? 8'hFF : mem[16'h8800];
      n_tests++;
      if (mem_rd !== !LOCK) begin
         n_fail++; $display("FAIL lock_vram_rd: rd=%b want %b", mem_rd, !LOCK);
      end
      @(negedge clk);
      n_tests++;
      if (cpu_rdata !== exp) begin
         n_fail++; $display("FAIL lock_vram_rdata: got %h want %h", cpu_rdata, exp);
      end
      drive_idle(); ppu_mode = 2'd0;
      $display("[TB] mode lock checked (lock=%0d)", LOCK);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem_rdata = 8'h00;
      drive_idle(); ppu_mode = 2'd0; rst = 0;
      test_reset();
      test_cpu_access();
      test_priority();
      test_dma_full(8'hC1);
      test_dma_full(8'hE5);
      test_dma_full(8'($urandom));
      test_dma_blocking();
      test_restart();
      test_reset_abort();
      test_mode_lock();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
